cordic_mag_post: RTL and testbench

//  Downstream of CoreCORDIC in vectoring mode. Removes the CORDIC gain from magnitude XN (x 1/1.646760).

---
 rtl/cordic_pkg.sv | 22 ++
 rtl/cordic_post_fifo.sv | 48 ++++
 rtl/cordic_mag_post.sv | 167 ++++++++++++++++
 tb/tb_cordic_mag_post.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC magnitude post-processing block.
// Entry layout in the output FIFO is {A, X, SOL, EOL}, tags in the two LSBs.
package cordic_pkg;

    localparam int unsigned INV_GAIN_Q17  = 79593;
    localparam int unsigned GAIN_FRAC_DEF = 17;
    localparam int unsigned GAIN_W        = 18;

    localparam int unsigned EOL_BIT = 0;
    localparam int unsigned SOL_BIT = 1;
    localparam int unsigned TAG_W   = 2;

    typedef struct packed {
        logic sol;
        logic eol;
    } line_tag_t;

    function automatic int unsigned fifo_entry_w(input int unsigned w);
        return 2 * w + TAG_W;
    endfunction

endpackage

// File: rtl/cordic_post_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rdata while !empty.
// A write into a full FIFO is accepted only when a read frees a slot in the same cycle.
module cordic_post_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic         CLK,
    input  logic         NGRST,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_rd;
    logic         w_do_wr;

    always_comb begin
        empty   = (r_wptr == r_rptr);
        full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
        w_do_rd = rd & ~empty;
        w_do_wr = wr & (~full | w_do_rd);
        rdata   = r_mem[r_rptr[AW-1:0]];
    end

    always_ff @(posedge CLK) begin
        if (!NGRST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_wr) r_wptr <= r_wptr + 1'b1;
            if (w_do_rd) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage is not reset: the pointers alone decide what is visible.
    always_ff @(posedge CLK) begin
        if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cordic_mag_post.sv
// CORDIC vectoring-mode post stage: removes the CORDIC gain from XN, keeps AN aligned,
// tags scan-line start/end and buffers results in a show-ahead FIFO with sticky overflow.
module cordic_mag_post
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH      = 48,
    parameter int unsigned INV_GAIN   = INV_GAIN_Q17,
    parameter int unsigned GAIN_FRAC  = GAIN_FRAC_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LINE_LEN   = 1024
) (
    input  logic             CLK,
    input  logic             NGRST,
    input  logic             DIN_VALID,
    input  logic [WIDTH-1:0] DIN_X,
    input  logic [WIDTH-1:0] DIN_A,
    input  logic             LINE_SYNC,
    input  logic             DOUT_READY,
    output logic             DOUT_VALID,
    output logic [WIDTH-1:0] DOUT_X,
    output logic [WIDTH-1:0] DOUT_A,
    output logic             DOUT_SOL,
    output logic             DOUT_EOL,
    output logic             OVFL,
    input  logic             CLR_OVFL
);

    localparam int unsigned PW    = WIDTH + GAIN_W;
    localparam int unsigned CW    = $clog2(LINE_LEN);
    localparam int unsigned EW    = fifo_entry_w(WIDTH);
    localparam int unsigned X_LSB = TAG_W;
    localparam int unsigned A_LSB = TAG_W + WIDTH;
    localparam logic [CW-1:0] LAST   = CW'(LINE_LEN - 1);
    localparam logic [PW-1:0] HALF   = PW'(1) << (GAIN_FRAC - 1);
    localparam logic [PW-1:0] GAIN_P = PW'(INV_GAIN);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    line_tag_t        w_tag;

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_x;
    logic [WIDTH-1:0] r_s1_a;
    line_tag_t        r_s1_tag;

    logic             r_s2_v;
    logic [PW-1:0]    r_s2_p;
    logic [WIDTH-1:0] r_s2_a;
    line_tag_t        r_s2_tag;

    logic             r_s3_v;
    logic [WIDTH-1:0] r_s3_x;
    logic [WIDTH-1:0] r_s3_a;
    line_tag_t        r_s3_tag;

    logic [WIDTH-1:0] w_xclamp;
    logic [PW-1:0]    w_prod;
    logic [WIDTH-1:0] w_rnd_x;

    logic [EW-1:0]    w_wdata;
    logic [EW-1:0]    w_rdata;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic             r_ovfl;

    // LINE_SYNC restarts the line: this sample is position 0, the next is position 1.
    always_comb begin
        w_tag.sol = (r_cnt == '0) || LINE_SYNC;
        w_tag.eol = (r_cnt == LAST) && !LINE_SYNC;
        if (LINE_SYNC)          w_cnt_nxt = CW'(1);
        else if (r_cnt == LAST) w_cnt_nxt = '0;
        else                    w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!NGRST) begin
            r_cnt    <= '0;
            r_s1_v   <= 1'b0;
            r_s1_x   <= '0;
            r_s1_a   <= '0;
            r_s1_tag <= '0;
        end else begin
            r_s1_v <= DIN_VALID;
            if (DIN_VALID) begin
                r_cnt    <= w_cnt_nxt;
                r_s1_x   <= DIN_X;
                r_s1_a   <= DIN_A;
                r_s1_tag <= w_tag;
            end
        end
    end

    always_comb begin
        w_xclamp = r_s1_x[WIDTH-1] ? '0 : r_s1_x;
        w_prod   = PW'(w_xclamp) * GAIN_P;
        w_rnd_x  = WIDTH'((r_s2_p + HALF) >> GAIN_FRAC);
    end

    always_ff @(posedge CLK) begin
        if (!NGRST) begin
            r_s2_v   <= 1'b0;
            r_s2_p   <= '0;
            r_s2_a   <= '0;
            r_s2_tag <= '0;
            r_s3_v   <= 1'b0;
            r_s3_x   <= '0;
            r_s3_a   <= '0;
            r_s3_tag <= '0;
        end else begin
            r_s2_v   <= r_s1_v;
            r_s2_p   <= w_prod;
            r_s2_a   <= r_s1_a;
            r_s2_tag <= r_s1_tag;
            r_s3_v   <= r_s2_v;
            r_s3_x   <= w_rnd_x;
            r_s3_a   <= r_s2_a;
            r_s3_tag <= r_s2_tag;
        end
    end

    always_comb begin
        w_wdata          = '0;
        w_wdata[A_LSB +: WIDTH] = r_s3_a;
        w_wdata[X_LSB +: WIDTH] = r_s3_x;
        w_wdata[SOL_BIT] = r_s3_tag.sol;
        w_wdata[EOL_BIT] = r_s3_tag.eol;
        w_drop           = r_s3_v & w_full & ~(DOUT_READY & ~w_empty);
    end

    cordic_post_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .NGRST (NGRST),
        .wr    (r_s3_v),
        .wdata (w_wdata),
        .rd    (DOUT_READY),
        .rdata (w_rdata),
        .empty (w_empty),
        .full  (w_full)
    );

    // A drop in the same cycle as CLR_OVFL keeps the flag set.
    always_ff @(posedge CLK) begin
        if (!NGRST)        r_ovfl <= 1'b0;
        else if (w_drop)   r_ovfl <= 1'b1;
        else if (CLR_OVFL) r_ovfl <= 1'b0;
    end

    always_comb begin
        OVFL       = r_ovfl;
        DOUT_VALID = ~w_empty;
        DOUT_X     = '0;
        DOUT_A     = '0;
        DOUT_SOL   = 1'b0;
        DOUT_EOL   = 1'b0;
        if (!w_empty) begin
            DOUT_X   = w_rdata[X_LSB +: WIDTH];
            DOUT_A   = w_rdata[A_LSB +: WIDTH];
            DOUT_SOL = w_rdata[SOL_BIT];
            DOUT_EOL = w_rdata[EOL_BIT];
        end
    end

endmodule

// File: tb/tb_cordic_mag_post.sv
// Self-checking bench for cordic_mag_post: randomized and directed samples against an
// arithmetic reference model of gain removal and line position, with an output scoreboard.
module tb_cordic_mag_post;

    localparam int unsigned W  = 48;
    localparam int unsigned LL = 4;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] a;
        logic         sol;
        logic         eol;
    } ent_t;

    logic         clk = 1'b0;
    logic         NGRST;
    logic         DIN_VALID;
    logic [W-1:0] DIN_X;
    logic [W-1:0] DIN_A;
    logic         LINE_SYNC;
    logic         DOUT_READY;
    logic         DOUT_VALID;
    logic [W-1:0] DOUT_X;
    logic [W-1:0] DOUT_A;
    logic         DOUT_SOL;
    logic         DOUT_EOL;
    logic         OVFL;
    logic         CLR_OVFL;

    int   n_vec = 0;
    int   n_err = 0;
    int   m_pos = 0;
    ent_t exp_q[$];
    ent_t got_q[$];

    always #5 clk = ~clk;

    cordic_mag_post #(
        .WIDTH      (W),
        .INV_GAIN   (79593),
        .GAIN_FRAC  (17),
        .FIFO_DEPTH (8),
        .LINE_LEN   (LL)
    ) dut (
        .CLK        (clk),
        .NGRST      (NGRST),
        .DIN_VALID  (DIN_VALID),
        .DIN_X      (DIN_X),
        .DIN_A      (DIN_A),
        .LINE_SYNC  (LINE_SYNC),
        .DOUT_READY (DOUT_READY),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_X     (DOUT_X),
        .DOUT_A     (DOUT_A),
        .DOUT_SOL   (DOUT_SOL),
        .DOUT_EOL   (DOUT_EOL),
        .OVFL       (OVFL),
        .CLR_OVFL   (CLR_OVFL)
    );

    // Handshake is decided by values stable since #1 after the rising edge.
    always @(negedge clk) begin
        if (NGRST === 1'b1 && DOUT_VALID === 1'b1 && DOUT_READY === 1'b1)
            got_q.push_back('{x: DOUT_X, a: DOUT_A, sol: DOUT_SOL, eol: DOUT_EOL});
    end

    // Reference: magnitude = round(max(X,0) * 79593 / 2^17), position counted within the line.
    function automatic ent_t model(input logic [W-1:0] x, input logic [W-1:0] a, input logic sync);
        ent_t        e;
        logic [65:0] m;
        if (sync) m_pos = 0;
        m     = x[W-1] ? 66'd0 : {18'd0, x};
        m     = (m * 66'd79593 + 66'd65536) / 66'd131072;
        e.x   = m[W-1:0];
        e.a   = a;
        e.sol = (m_pos == 0);
        e.eol = (m_pos == LL - 1);
        m_pos = (m_pos + 1) % LL;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] a, input logic sync);
        DIN_VALID = v;
        DIN_X     = x;
        DIN_A     = a;
        LINE_SYNC = sync;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] a, input logic sync, input bit keep);
        ent_t e;
        e = model(x, a, sync);
        if (keep) exp_q.push_back(e);
        drive(1'b1, x, a, sync);
    endtask

    task automatic do_reset();
        NGRST      = 1'b0;
        CLR_OVFL   = 1'b0;
        DOUT_READY = 1'b0;
        idle(2);
        NGRST = 1'b1;
        exp_q.delete();
        got_q.delete();
        m_pos = 0;
    endtask

    task automatic wait_drain(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        idle(4);
    endtask

    task automatic test_reset();
        NGRST      = 1'b0;
        CLR_OVFL   = 1'b0;
        DOUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, rnd48(), rnd48(), 1'b0);
            n_vec++;
            if ({DOUT_VALID, DOUT_X, DOUT_A, DOUT_SOL, DOUT_EOL, OVFL} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs[%0d]: got v=%b x=%h a=%h sol=%b eol=%b ovfl=%b, expected all 0",
                         i, DOUT_VALID, DOUT_X, DOUT_A, DOUT_SOL, DOUT_EOL, OVFL);
            end
        end
        NGRST = 1'b1;
        idle(6);
        n_vec++;
        if (DOUT_VALID !== 1'b0 || got_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_empty: got valid=%b outputs=%0d, expected valid=0 outputs=0", DOUT_VALID, got_q.size());
        end
    endtask

    task automatic test_gain();
        logic [W-1:0] dir_x[5];
        logic [W-1:0] a0;
        bit           ok;
        do_reset();
        DOUT_READY = 1'b1;
        dir_x[0] = 48'd131072;
        dir_x[1] = 48'd1 << 40;
        dir_x[2] = 48'd1;
        dir_x[3] = 48'd0;
        dir_x[4] = -48'sd5;
        a0 = rnd48();
        send(dir_x[0], a0, 1'b0, 1'b1);
        for (int j = 1; j <= 3; j++) begin
            n_vec++;
            if (DOUT_VALID !== 1'b0) begin
                n_err++;
                $display("FAIL gain_latency_early[n+%0d]: got valid=%b, expected 0", j, DOUT_VALID);
            end
            idle(1);
        end
        n_vec++;
        if (DOUT_VALID !== 1'b1 || DOUT_X !== 48'd79593 || DOUT_A !== a0) begin
            n_err++;
            $display("FAIL gain_latency_n+4: got valid=%b x=%0d a=%h, expected valid=1 x=79593 a=%h",
                     DOUT_VALID, DOUT_X, DOUT_A, a0);
        end
        for (int i = 1; i < 5; i++) send(dir_x[i], rnd48(), 1'b0, 1'b1);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(rnd48(), rnd48(), 1'b0, 1'b1);
        end
        wait_drain(exp_q.size(), ok);
        n_vec++;
        if (!ok || got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL gain_count: got %0d outputs, expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL gain_entry[%0d]: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=%b eol=%b",
                         i, got_q[i].x, got_q[i].a, got_q[i].sol, got_q[i].eol,
                         exp_q[i].x, exp_q[i].a, exp_q[i].sol, exp_q[i].eol);
            end
        end
        n_vec++;
        if (got_q.size() > 1 && got_q[1].x !== 48'd667674476544) begin
            n_err++;
            $display("FAIL gain_2pow40: got %0d, expected 667674476544", got_q[1].x);
        end
    endtask

    task automatic test_framing();
        logic [13:0] sol_got;
        logic [13:0] eol_got;
        bit          ok;
        do_reset();
        DOUT_READY = 1'b1;
        for (int i = 0; i < 14; i++) send(rnd48(), rnd48(), (i == 10), 1'b1);
        wait_drain(14, ok);
        sol_got = '0;
        eol_got = '0;
        for (int i = 0; i < 14 && i < got_q.size(); i++) begin
            sol_got[i] = got_q[i].sol;
            eol_got[i] = got_q[i].eol;
        end
        n_vec++;
        if (!ok || got_q.size() != 14) begin
            n_err++;
            $display("FAIL framing_count: got %0d outputs, expected 14", got_q.size());
        end
        n_vec++;
        if (sol_got !== 14'd1297) begin
            n_err++;
            $display("FAIL framing_sol: got %b, expected %b", sol_got, 14'd1297);
        end
        n_vec++;
        if (eol_got !== 14'd8328) begin
            n_err++;
            $display("FAIL framing_eol: got %b, expected %b", eol_got, 14'd8328);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL framing_entry[%0d]: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=%b eol=%b",
                         i, got_q[i].x, got_q[i].a, got_q[i].sol, got_q[i].eol,
                         exp_q[i].x, exp_q[i].a, exp_q[i].sol, exp_q[i].eol);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        DOUT_READY = 1'b0;
        for (int i = 0; i < 12; i++) send(rnd48(), rnd48(), 1'b0, (i < 8));
        for (int i = 0; i < 6; i++) begin
            idle(1);
            n_vec++;
            if (DOUT_VALID !== 1'b1 || DOUT_X !== exp_q[0].x || DOUT_A !== exp_q[0].a) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got valid=%b x=%0d a=%h, expected valid=1 x=%0d a=%h",
                         i, DOUT_VALID, DOUT_X, DOUT_A, exp_q[0].x, exp_q[0].a);
            end
        end
        n_vec++;
        if (OVFL !== 1'b1 || got_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_ovfl_set: got ovfl=%b outputs=%0d, expected ovfl=1 outputs=0", OVFL, got_q.size());
        end
        DOUT_READY = 1'b1;
        wait_drain(8, ok);
        n_vec++;
        if (!ok || got_q.size() != 8) begin
            n_err++;
            $display("FAIL bp_count: got %0d outputs, expected 8", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL bp_entry[%0d]: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=%b eol=%b",
                         i, got_q[i].x, got_q[i].a, got_q[i].sol, got_q[i].eol,
                         exp_q[i].x, exp_q[i].a, exp_q[i].sol, exp_q[i].eol);
            end
        end
        n_vec++;
        if (OVFL !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ovfl_sticky: got %b, expected 1", OVFL);
        end
        CLR_OVFL = 1'b1;
        idle(1);
        CLR_OVFL = 1'b0;
        n_vec++;
        if (OVFL !== 1'b0) begin
            n_err++;
            $display("FAIL bp_ovfl_clear: got %b, expected 0", OVFL);
        end
    endtask

    task automatic test_full_rw();
        bit ok;
        do_reset();
        DOUT_READY = 1'b0;
        // Sample 7 lands at the end of cycle 10, so reading from cycle 11 meets a full FIFO on every write.
        for (int i = 0; i < 28; i++) begin
            DOUT_READY = (i >= 11);
            send(rnd48(), rnd48(), 1'b0, 1'b1);
        end
        DOUT_READY = 1'b1;
        wait_drain(28, ok);
        n_vec++;
        if (!ok || got_q.size() != 28 || OVFL !== 1'b0) begin
            n_err++;
            $display("FAIL full_rw_count: got %0d outputs ovfl=%b, expected 28 outputs ovfl=0", got_q.size(), OVFL);
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL full_rw_entry[%0d]: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=%b eol=%b",
                         i, got_q[i].x, got_q[i].a, got_q[i].sol, got_q[i].eol,
                         exp_q[i].x, exp_q[i].a, exp_q[i].sol, exp_q[i].eol);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent  = 0;
        int iters = 0;
        bit ok;
        do_reset();
        while (sent < 40 && iters < 1000) begin
            iters++;
            DOUT_READY = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 && (sent - got_q.size()) < 8) begin
                send(rnd48(), rnd48(), ($urandom_range(0, 9) == 0), 1'b1);
                sent++;
            end else begin
                idle(1);
            end
        end
        DOUT_READY = 1'b1;
        wait_drain(exp_q.size(), ok);
        n_vec++;
        if (!ok || got_q.size() != exp_q.size() || OVFL !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_count: got %0d outputs ovfl=%b, expected %0d outputs ovfl=0",
                     got_q.size(), OVFL, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_entry[%0d]: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=%b eol=%b",
                         i, got_q[i].x, got_q[i].a, got_q[i].sol, got_q[i].eol,
                         exp_q[i].x, exp_q[i].a, exp_q[i].sol, exp_q[i].eol);
            end
        end
    endtask

    task automatic test_midstream_reset();
        bit ok;
        do_reset();
        DOUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) send(rnd48(), rnd48(), 1'b0, 1'b0);
        NGRST = 1'b0;
        idle(1);
        NGRST = 1'b1;
        m_pos = 0;
        idle(8);
        n_vec++;
        if (got_q.size() != 0 || DOUT_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_discard: got %0d outputs valid=%b, expected 0 outputs valid=0",
                     got_q.size(), DOUT_VALID);
        end
        send(rnd48(), rnd48(), 1'b0, 1'b1);
        wait_drain(1, ok);
        n_vec++;
        if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0] || got_q[0].sol !== 1'b1) begin
            n_err++;
            if (got_q.size() > 0)
                $display("FAIL midreset_next: got x=%0d a=%h sol=%b eol=%b, expected x=%0d a=%h sol=1 eol=0",
                         got_q[0].x, got_q[0].a, got_q[0].sol, got_q[0].eol, exp_q[0].x, exp_q[0].a);
            else
                $display("FAIL midreset_next: got 0 outputs, expected 1");
        end
    endtask

    initial begin
        NGRST      = 1'b0;
        DIN_VALID  = 1'b0;
        DIN_X      = '0;
        DIN_A      = '0;
        LINE_SYNC  = 1'b0;
        DOUT_READY = 1'b0;
        CLR_OVFL   = 1'b0;
        #1;
        test_reset();
        test_gain();
        test_framing();
        test_backpressure();
        test_full_rw();
        test_back_to_back();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
